// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB, decodes
// the latched instruction and drives every datapath enable and mux select.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        bgez,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        mem_write,
  output logic [2:0]  state,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SLLV = 3'd4;
  localparam logic [2:0] W_MEM_WAIT = 3'(MEM_WAIT);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;

  logic [5:0] w_op, w_funct;
  logic [4:0] w_rt;
  logic       w_rtype, w_addu, w_subu, w_sllv, w_jr;
  logic       w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_bgez;
  logic       w_ir_write, w_pc_write, w_reg_write, w_mem_write;
  logic       w_unused;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rt    = instr[20:16];
  assign w_unused = ^{instr[25:21], instr[15:6]};

  assign w_rtype = (w_op == 6'b000000);
  assign w_addu  = w_rtype && (w_funct == 6'b100001);
  assign w_subu  = w_rtype && (w_funct == 6'b100011);
  assign w_sllv  = w_rtype && (w_funct == 6'b000100);
  assign w_jr    = w_rtype && (w_funct == 6'b001000);
  assign w_ori   = (w_op == 6'b001101);
  assign w_lui   = (w_op == 6'b001111);
  assign w_lw    = (w_op == 6'b100011);
  assign w_sw    = (w_op == 6'b101011);
  assign w_beq   = (w_op == 6'b000100);
  assign w_j     = (w_op == 6'b000010);
  assign w_jal   = (w_op == 6'b000011);
  assign w_bgez  = (w_op == 6'b000001) && (w_rt == 5'b00001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_FETCH;
    w_cnt_nxt   = r_cnt;
    alu_op      = OP_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    ext_op      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    pc_src      = 2'd0;
    w_reg_write = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    w_mem_write = 1'b0;
    instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        alu_src_b   = 2'd1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_j || w_jal) begin
          w_pc_write = 1'b1;
          pc_src     = 2'd2;
        end
        if (w_jal) begin
          w_reg_write = 1'b1;
          reg_dst     = 2'd2;
          mem_to_reg  = 2'd2;
        end
        if (w_jr) begin
          w_pc_write = 1'b1;
          pc_src     = 2'd3;
        end
        if (w_addu || w_subu || w_sllv || w_ori || w_lui || w_lw || w_sw || w_beq || w_bgez)
          w_state_nxt = S_EXEC;
        else
          instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (w_addu || w_subu || w_sllv) begin
          alu_op      = w_subu ? OP_SUB : (w_sllv ? OP_SLLV : OP_ADD);
          w_state_nxt = S_WB;
        end else if (w_ori || w_lui) begin
          alu_src_b   = 2'd2;
          alu_op      = w_ori ? OP_OR : OP_LUI;
          w_state_nxt = S_WB;
        end else if (w_lw || w_sw) begin
          alu_src_b   = 2'd2;
          ext_op      = 1'b1;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_MEM;
        end else if (w_beq || w_bgez) begin
          alu_op     = w_beq ? OP_SUB : OP_ADD;
          pc_src     = 2'd1;
          w_pc_write = w_beq ? zero : bgez;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        // Address computation stays on the ALU for the whole memory access.
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
        if (r_cnt < W_MEM_WAIT) begin
          w_cnt_nxt   = r_cnt + 3'd1;
          w_state_nxt = S_MEM;
        end else if (w_lw) begin
          w_state_nxt = S_WB;
        end else if (w_sw) begin
          w_mem_write = 1'b1;
          instr_done  = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
        reg_dst     = w_rtype ? 2'd1 : 2'd0;
        mem_to_reg  = w_lw ? 2'd1 : 2'd0;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Reset masks every write enable so an abandoned instruction cannot commit.
  assign ir_write  = w_ir_write  & ~reset;
  assign pc_write  = w_pc_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign state     = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected output traces are queued by
// the driver and popped/compared every cycle by an independent monitor.
module tb_mc_ctrl_fsm;
  localparam int MEM_WAIT = 2;

  localparam int C_ADDU = 0, C_SUBU = 1, C_SLLV = 2, C_JR = 3, C_ORI = 4, C_LUI = 5;
  localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10, C_BGEZ = 11, C_UNK = 12;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext;
    logic       ir_w;
    logic       pc_w;
    logic [1:0] pc_src;
    logic       reg_w;
    logic [1:0] reg_dst;
    logic [1:0] m2r;
    logic       mem_w;
    logic [2:0] st;
    logic       done;
  } vec_t;
  localparam int VW = $bits(vec_t);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        bgez = 1'b0;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_op;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        mem_write;
  logic [2:0]  state;
  logic        instr_done;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got_v;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  mc_ctrl_fsm #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .bgez(bgez),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign got_v = {alu_op, alu_src_a, alu_src_b, ext_op, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, mem_write, state, instr_done};

  // ---------------- clock/reset-independent helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_instr(input int cls);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case (cls)
      C_ADDU: return {6'b000000, rs, rt, rd, sh, 6'b100001};
      C_SUBU: return {6'b000000, rs, rt, rd, sh, 6'b100011};
      C_SLLV: return {6'b000000, rs, rt, rd, sh, 6'b000100};
      C_JR:   return {6'b000000, rs, rt, rd, sh, 6'b001000};
      C_ORI:  return {6'b001101, rs, rt, imm};
      C_LUI:  return {6'b001111, rs, rt, imm};
      C_LW:   return {6'b100011, rs, rt, imm};
      C_SW:   return {6'b101011, rs, rt, imm};
      C_BEQ:  return {6'b000100, rs, rt, imm};
      C_J:    return {6'b000010, tgt};
      C_JAL:  return {6'b000011, tgt};
      C_BGEZ: return {6'b000001, rs, 5'b00001, imm};
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0000;
          1: return {6'b000001, rs, 5'b00000, imm};
          2: return {6'b001000, rs, rt, imm};
          3: return {6'b000000, rs, rt, rd, sh, 6'b100000};
          default: return {6'b100000, rs, rt, imm};
        endcase
      end
    endcase
  endfunction

  // Reference model: builds the cycle-by-cycle output trace of one instruction.
  task automatic push_trace(input int cls, input logic z, input logic b, output int n);
    vec_t v;
    n = 0;
    v = '0; v.src_b = 2'd1; v.ir_w = 1'b1; v.pc_w = 1'b1; v.st = 3'd0;
    exp_q.push_back(v); n++;
    v = '0; v.st = 3'd1;
    if (cls == C_J || cls == C_JAL || cls == C_JR || cls == C_UNK) begin
      v.done = 1'b1;
      if (cls == C_J || cls == C_JAL) begin v.pc_w = 1'b1; v.pc_src = 2'd2; end
      if (cls == C_JAL) begin v.reg_w = 1'b1; v.reg_dst = 2'd2; v.m2r = 2'd2; end
      if (cls == C_JR) begin v.pc_w = 1'b1; v.pc_src = 2'd3; end
      exp_q.push_back(v); n++;
      return;
    end
    exp_q.push_back(v); n++;
    v = '0; v.st = 3'd2; v.src_a = 1'b1;
    case (cls)
      C_SUBU: v.alu_op = 3'd1;
      C_SLLV: v.alu_op = 3'd4;
      C_ORI:  begin v.src_b = 2'd2; v.alu_op = 3'd2; end
      C_LUI:  begin v.src_b = 2'd2; v.alu_op = 3'd3; end
      C_LW, C_SW: begin v.src_b = 2'd2; v.ext = 1'b1; end
      C_BEQ:  begin v.alu_op = 3'd1; v.pc_src = 2'd1; v.pc_w = z; v.done = 1'b1; end
      C_BGEZ: begin v.pc_src = 2'd1; v.pc_w = b; v.done = 1'b1; end
      default: v.alu_op = 3'd0;
    endcase
    exp_q.push_back(v); n++;
    if (cls == C_BEQ || cls == C_BGEZ) return;
    if (cls == C_LW || cls == C_SW) begin
      for (int k = 0; k <= MEM_WAIT; k++) begin
        v = '0; v.st = 3'd3; v.src_a = 1'b1; v.src_b = 2'd2; v.ext = 1'b1;
        if (k == MEM_WAIT && cls == C_SW) begin v.mem_w = 1'b1; v.done = 1'b1; end
        exp_q.push_back(v); n++;
      end
      if (cls == C_SW) return;
    end
    v = '0; v.st = 3'd4; v.reg_w = 1'b1; v.done = 1'b1;
    v.reg_dst = (cls == C_ADDU || cls == C_SUBU || cls == C_SLLV) ? 2'd1 : 2'd0;
    v.m2r = (cls == C_LW) ? 2'd1 : 2'd0;
    exp_q.push_back(v); n++;
  endtask

  // ---------------- driver ----------------
  task automatic run_one(input int cls, input logic [31:0] ins, input logic z, input logic b);
    int n;
    instr = ins; zero = z; bgez = b;
    push_trace(cls, z, b, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int count);
    int cls;
    for (int i = 0; i < count; i++) begin
      cls = $urandom_range(0, 12);
      run_one(cls, gen_instr(cls), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL trace_underflow: got state %0d with no expected cycle (t=%0t)", state, $time);
      end else begin
        logic [VW-1:0] e;
        e = exp_q.pop_front();
        if (got_v !== e) begin
          fails++;
          $display("FAIL cycle_outputs: instr=%h state=%0d got %h expected %h (t=%0t)",
                   instr, state, got_v, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_wen", 32'({ir_write, pc_write, reg_write, mem_write}), 32'd0);
    check("reset_srcb", 32'(alu_src_b), 32'd1);
    check("reset_done", 32'(instr_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    run_one(C_ADDU, 32'h0022_1821, 1'b0, 1'b0);
    run_one(C_LW,   32'h8C22_0004, 1'b1, 1'b0);
    run_one(C_SW,   32'hAC22_0004, 1'b0, 1'b1);
    run_one(C_BEQ,  32'h1022_0003, 1'b1, 1'b0);
    run_one(C_BEQ,  32'h1022_0003, 1'b0, 1'b1);
    run_one(C_JAL,  32'h0C00_0010, 1'b0, 1'b0);
    run_one(C_BGEZ, 32'h0421_0002, 1'b0, 1'b1);
    run_one(C_BGEZ, 32'h0421_0002, 1'b1, 1'b0);
    run_one(C_J,    32'h0800_0040, 1'b0, 1'b0);
    run_one(C_JR,   32'h03E0_0008, 1'b0, 1'b0);
    run_one(C_UNK,  32'h0000_0000, 1'b1, 1'b1);
    run_random(300);

    // Abandon a lw in MEM with an asynchronous reset.
    mon_en = 1'b0;
    check("queue_drained_pre_abort", 32'(exp_q.size()), 32'd0);
    instr = 32'h8C22_0004;
    repeat (3) @(posedge clk); #1;
    check("abort_in_mem", 32'(state), 32'd3);
    reset = 1'b1; #1;
    check("abort_async_state", 32'(state), 32'd0);
    check("abort_async_wen", 32'({ir_write, pc_write, reg_write, mem_write}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_state", 32'(state), 32'd0);
      check("abort_hold_wen", 32'({ir_write, pc_write, reg_write, mem_write}), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("post_abort_fetch", 32'({state, ir_write, pc_write, reg_write, mem_write}), 32'b000_1100);
    mon_en = 1'b1;
    run_random(50);

    mon_en = 1'b0;
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
